// File: rtl/ddr_sim_pkg.sv
// Shared types and constants for the behavioural DDR model.
package ddr_sim_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_VALID = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ddr_sim_rdq.sv
// Read-address FIFO; each entry carries a saturating age (cycles since accept).
module ddr_sim_rdq
    import ddr_sim_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 16,
    parameter int AGE_W   = 2,
    parameter int AGE_MAX = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_addr,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] head_addr,
    output logic [AGE_W-1:0] head_age,
    output logic             next_valid,
    output logic [IDX_W-1:0] next_addr,
    output logic [AGE_W-1:0] next_age
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] addr_mem [DEPTH];
    logic [AGE_W-1:0] age_mem  [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign rd_ptr_nx  = rd_ptr + 1'b1;
    assign head_addr  = addr_mem[rd_ptr];
    assign head_age   = age_mem[rd_ptr];
    // The entry behind the head lets the output stage stream one word per cycle.
    assign next_valid = (count > CNT_W'(1));
    assign next_addr  = addr_mem[rd_ptr_nx];
    assign next_age   = age_mem[rd_ptr_nx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                age_mem[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age_mem[i] < AGE_W'(AGE_MAX)) age_mem[i] <= age_mem[i] + 1'b1;
            end
            // Age 1 after the accept edge, so age == N on the Nth edge after accept.
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                age_mem[wr_ptr]  <= AGE_W'(1);
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr_nx;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_sim_model.sv
// Behavioural DDR memory model: calibration delay, latency-queued reads, acked writes.
// Optional byte-mask writes are enabled with the DDR_SIM_MODEL_WRMASK_EN macro.
module ddr_sim_model
    import ddr_sim_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int MEM_WORDS  = 65536,
    parameter int RD_LAT     = 3,
    parameter int RDQ_DEPTH  = 16,
    parameter int WR_ACK_LAT = 8,
    parameter int WR_MAX_OUT = 4,
    parameter int CAL_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rd_addr_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_busy,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_en,
    input  logic                wr_addr_en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_datamask,
    output logic                wr_ack,
    output logic                wr_busy,
    output logic                cal_done,
    output logic                cal_pass,
    output rd_state_t           rd_state
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int AGE_W = $clog2(RD_LAT + 1);
    localparam int BYTES = DATA_W / 8;
    localparam int CAL_W = $clog2(CAL_CYCLES + 1);
    localparam int OUT_W = $clog2(WR_MAX_OUT + 1);

    logic [DATA_W-1:0]     mem [MEM_WORDS];
    logic                  rd_accept;
    logic                  rd_pop;
    logic                  q_full;
    logic                  q_empty;
    logic                  next_valid;
    logic [IDX_W-1:0]      head_addr;
    logic [IDX_W-1:0]      next_addr;
    logic [IDX_W-1:0]      fetch_addr;
    logic [IDX_W-1:0]      widx;
    logic [AGE_W-1:0]      head_age;
    logic [AGE_W-1:0]      next_age;
    logic                  head_aged;
    logic                  next_aged;
    logic                  wr_fire;
    logic [DATA_W-1:0]     wr_word;
    logic [DATA_W-1:0]     fetch_word;
    logic [CAL_W-1:0]      cal_cnt;
    logic [OUT_W-1:0]      wr_out;
    logic [WR_ACK_LAT-1:0] ack_pipe;
    logic                  unused_addr;

    // Valid/ready: a read is accepted when rd_addr_en & !rd_busy, a word is consumed
    // when rd_valid & rd_en, a write is accepted when wr_en & wr_addr_en & !wr_busy.
    assign rd_busy   = ~cal_done | q_full;
    assign wr_busy   = ~cal_done | (wr_out == OUT_W'(WR_MAX_OUT));
    assign rd_accept = rd_addr_en & ~rd_busy;
    assign rd_pop    = rd_valid & rd_en;
    assign wr_fire   = wr_en & wr_addr_en & ~wr_busy;
    assign widx      = wr_addr[IDX_W-1:0];
    assign head_aged = (head_age >= AGE_W'(RD_LAT));
    assign next_aged = (next_age >= AGE_W'(RD_LAT));
    assign unused_addr = ^{rd_addr[ADDR_W-1:IDX_W], wr_addr[ADDR_W-1:IDX_W]};

`ifdef DDR_SIM_MODEL_WRMASK_EN
    always_comb begin
        wr_word = wr_data;
        for (int b = 0; b < BYTES; b++) begin
            if (wr_datamask[b]) wr_word[8*b +: 8] = mem[widx][8*b +: 8];
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^wr_datamask;
    assign wr_word     = wr_data;
`endif

    // A write committed on the same edge the read samples must be seen, so bypass it.
    assign fetch_addr = (rd_state == RD_VALID) ? next_addr : head_addr;
    assign fetch_word = (wr_fire && (widx == fetch_addr)) ? wr_word : mem[fetch_addr];

    ddr_sim_rdq #(
        .DEPTH   (RDQ_DEPTH),
        .IDX_W   (IDX_W),
        .AGE_W   (AGE_W),
        .AGE_MAX (RD_LAT)
    ) u_rdq (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rd_accept),
        .push_addr  (rd_addr[IDX_W-1:0]),
        .pop        (rd_pop),
        .full       (q_full),
        .empty      (q_empty),
        .head_addr  (head_addr),
        .head_age   (head_age),
        .next_valid (next_valid),
        .next_addr  (next_addr),
        .next_age   (next_age)
    );

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[widx] <= wr_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= RD_IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (rd_state)
                RD_VALID: begin
                    if (rd_en) begin
                        if (next_valid && next_aged) begin
                            rd_data <= fetch_word;
                        end else begin
                            rd_valid <= 1'b0;
                            rd_state <= next_valid ? RD_WAIT : RD_IDLE;
                        end
                    end
                end
                default: begin
                    if (q_empty) begin
                        rd_state <= RD_IDLE;
                    end else if (head_aged) begin
                        rd_state <= RD_VALID;
                        rd_valid <= 1'b1;
                        rd_data  <= fetch_word;
                    end else begin
                        rd_state <= RD_WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cal_cnt  <= '0;
            cal_done <= 1'b0;
            cal_pass <= 1'b0;
            ack_pipe <= '0;
            wr_ack   <= 1'b0;
            wr_out   <= '0;
        end else begin
            if (!cal_done) begin
                cal_cnt <= cal_cnt + 1'b1;
                if (cal_cnt == CAL_W'(CAL_CYCLES - 1)) begin
                    cal_done <= 1'b1;
                    cal_pass <= 1'b1;
                end
            end
            // The outstanding count drops on the edge that raises wr_ack.
            ack_pipe <= (ack_pipe << 1) | WR_ACK_LAT'(wr_fire);
            wr_ack   <= ack_pipe[WR_ACK_LAT-1];
            wr_out   <= wr_out + OUT_W'(wr_fire) - OUT_W'(ack_pipe[WR_ACK_LAT-1]);
        end
    end

endmodule
